adder_operand_sequencer: RTL and testbench



---
 rtl/adder_operand_sequencer.sv | 126 ++++++++++++
 tb/tb_adder_operand_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_sequencer.sv
// Operand/result sequencer around an external combinational WIDTH-bit adder.
// Optional signed-overflow flag: define OVERFLOW_FLAG_EN; otherwise OVF is tied to 0.
module adder_operand_sequencer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH/2-1:0] IN_DATA,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   SUM_IN,
    output logic [WIDTH-1:0]   RESULT,
    output logic               OVF,
    output logic               OUT_VALID,
    input  logic               OUT_READY
);

    localparam int unsigned HALF = WIDTH / 2;

    typedef enum logic [2:0] {
        LD_A_LO,
        LD_A_HI,
        LD_B_LO,
        LD_B_HI,
        ADD,
        OUT
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   beat;
    logic   done;

    assign beat = IN_VALID & IN_READY;
    assign done = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= LD_A_LO;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs decode from state only, never from IN_VALID/OUT_READY.
    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state)
            LD_A_LO: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_nxt = LD_A_HI;
            end
            LD_A_HI: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_nxt = LD_B_LO;
            end
            LD_B_LO: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_nxt = LD_B_HI;
            end
            LD_B_HI: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_nxt = ADD;
            end
            ADD: begin
                state_nxt = OUT;
            end
            OUT: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_nxt = LD_A_LO;
            end
            default: begin
                state_nxt = LD_A_LO;
            end
        endcase
    end

    // Each beat updates only its own half; the other half keeps its old value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            A <= '0;
            B <= '0;
        end else if (beat) begin
            case (state)
                LD_A_LO: A[HALF-1:0]     <= IN_DATA;
                LD_A_HI: A[WIDTH-1:HALF] <= IN_DATA;
                LD_B_LO: B[HALF-1:0]     <= IN_DATA;
                LD_B_HI: B[WIDTH-1:HALF] <= IN_DATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RESULT <= '0;
        end else if (state == ADD) begin
            RESULT <= SUM_IN;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q;

    // Same-sign operands producing a sum of the opposite sign.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (state == ADD) begin
            ovf_q <= (A[WIDTH-1] == B[WIDTH-1]) && (SUM_IN[WIDTH-1] != A[WIDTH-1]);
        end
    end

    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif

    logic unused_done;
    assign unused_done = done;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Randomized self-checking bench for adder_operand_sequencer; models the external
// adder and predicts results at transaction level from the beats it sends.
module tb_adder_operand_sequencer;

    localparam int unsigned W  = 64;
    localparam int unsigned HW = W / 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [HW-1:0] IN_DATA = '0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [W-1:0]  SUM_IN;
    logic [W-1:0]  RESULT;
    logic          OVF;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;

    adder_operand_sequencer #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .SUM_IN    (SUM_IN),
        .RESULT    (RESULT),
        .OVF       (OVF),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    // External Behavioral_Adder stand-in.
    assign SUM_IN = A + B;

    always #5 CLK = ~CLK;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    // Transaction-level reference: beats taken so far, pending add, pending result.
    int unsigned  m_cnt = 0;
    bit           m_add = 1'b0;
    bit           m_out = 1'b0;
    logic [W-1:0] mA = '0;
    logic [W-1:0] mB = '0;
    logic [W-1:0] m_res = '0;
    logic         m_ovf = 1'b0;

    bit           last_in_x;
    bit           last_out_x;
    bit           last_ov;
    logic [W-1:0] last_res;
    logic         last_ovf;

    logic [W-1:0] opa_q[$];
    logic [W-1:0] opb_q[$];

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic signed_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] s;
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        return (s > $signed({2'b00, {(W-1){1'b1}}})) || (s < -$signed({2'b01, {(W-1){1'b0}}}));
    endfunction

    // Called at posedge+1: drives one cycle, checks at negedge, advances the model after the edge.
    task automatic step(input logic iv, input logic [HW-1:0] d, input logic ordy);
        IN_VALID  = iv;
        IN_DATA   = d;
        OUT_READY = ordy;
        @(negedge CLK);
        check_eq("in_ready", W'(IN_READY), W'(!m_add && !m_out));
        check_eq("out_valid", W'(OUT_VALID), W'(m_out));
        check_eq("op_a", A, mA);
        check_eq("op_b", B, mB);
        if (m_out) begin
            check_eq("result", RESULT, m_res);
            check_eq("ovf", W'(OVF), W'(m_ovf));
        end
        last_in_x  = iv && !m_add && !m_out;
        last_out_x = ordy && m_out;
        last_ov    = m_out;
        if (last_out_x) begin
            last_res = RESULT;
            last_ovf = OVF;
        end
        @(posedge CLK);
        #1;
        if (last_in_x) begin
            case (m_cnt)
                0: mA[HW-1:0] = d;
                1: mA[W-1:HW] = d;
                2: mB[HW-1:0] = d;
                default: mB[W-1:HW] = d;
            endcase
            m_cnt++;
            if (m_cnt == 4) m_add = 1'b1;
        end else if (m_add) begin
            m_add = 1'b0;
            m_out = 1'b1;
            m_res = mA + mB;
`ifdef OVERFLOW_FLAG_EN
            m_ovf = signed_ovf(mA, mB);
`else
            m_ovf = 1'b0;
`endif
        end else if (last_out_x) begin
            m_out = 1'b0;
            m_cnt = 0;
        end
    endtask

    // Called at posedge+1: asserts reset mid-cycle, holds it across an edge with junk input.
    task automatic pulse_reset();
        #2 RST = 1'b1;
        IN_VALID  = 1'b1;
        IN_DATA   = HW'($urandom);
        OUT_READY = 1'b0;
        #1;
        check_eq("rst_result", RESULT, '0);
        check_eq("rst_ovf", W'(OVF), '0);
        check_eq("rst_out_valid", W'(OUT_VALID), '0);
        check_eq("rst_a", A, '0);
        check_eq("rst_b", B, '0);
        check_eq("rst_in_ready", W'(IN_READY), W'(1));
        m_cnt = 0;
        m_add = 1'b0;
        m_out = 1'b0;
        mA    = '0;
        mB    = '0;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // Sends every queued operand pair as beats and drains all results.
    task automatic stream(input int unsigned gap_pct, input int unsigned ordy_pct,
                          input int unsigned hold_low);
        logic [HW-1:0] bq[$];
        int unsigned   n_exp;
        int unsigned   n_out = 0;
        int unsigned   low = 0;
        int unsigned   guard = 0;
        n_exp = opa_q.size();
        while (opa_q.size() > 0) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = opa_q.pop_front();
            b = opb_q.pop_front();
            bq.push_back(a[HW-1:0]);
            bq.push_back(a[W-1:HW]);
            bq.push_back(b[HW-1:0]);
            bq.push_back(b[W-1:HW]);
        end
        while (n_out < n_exp && guard < 5000) begin
            logic          iv;
            logic          ordy;
            logic [HW-1:0] d;
            iv   = (bq.size() > 0) && ($urandom_range(99) >= gap_pct);
            d    = (bq.size() > 0) ? bq[0] : HW'($urandom);
            ordy = (low >= hold_low) && ($urandom_range(99) < ordy_pct);
            step(iv, d, ordy);
            if (last_in_x) void'(bq.pop_front());
            if (last_ov && !ordy) low++;
            if (last_out_x) begin
                n_out++;
                low = 0;
            end
            guard++;
        end
        check_eq("stream_results", W'(n_out), W'(n_exp));
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(5))
            0: return '1;
            1: return {1'b0, {(W-1){1'b1}}};
            2: return {1'b1, {(W-1){1'b0}}};
            3: return W'(1);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        @(posedge CLK);
        #1;
        pulse_reset();
        step(1'b0, '0, 1'b0);

        // Max positive + max positive: wraps to ...FE, signed overflow.
        opa_q.push_back(64'h7FFFFFFF_FFFFFFFF);
        opb_q.push_back(64'h7FFFFFFF_FFFFFFFF);
        stream(0, 100, 0);
        check_eq("dir_maxpos_result", last_res, 64'hFFFFFFFF_FFFFFFFE);
`ifdef OVERFLOW_FLAG_EN
        check_eq("dir_maxpos_ovf", W'(last_ovf), W'(1));
`else
        check_eq("dir_maxpos_ovf", W'(last_ovf), W'(0));
`endif

        // -1 + 1 wraps to zero without overflow.
        opa_q.push_back('1);
        opb_q.push_back(64'h1);
        stream(0, 100, 0);
        check_eq("dir_wrap_result", last_res, '0);
        check_eq("dir_wrap_ovf", W'(last_ovf), '0);

        // Back-to-back operands with IN_VALID held high through ADD/OUT.
        opa_q.push_back(64'h01234567_89ABCDEF);
        opb_q.push_back(64'h11111111_22222222);
        opa_q.push_back(64'hDEADBEEF_CAFEF00D);
        opb_q.push_back(64'h0F0F0F0F_F0F0F0F0);
        stream(0, 100, 0);
        check_eq("b2b_second_result", last_res, 64'hEDBCCDFF_BBEFE0FD);

        // Downstream stalls 10 cycles per result.
        opa_q.push_back(64'h00000000_FFFFFFFF);
        opb_q.push_back(64'h00000000_00000001);
        stream(0, 100, 10);
        check_eq("stall_result", last_res, 64'h00000001_00000000);

        // Same operands with random input gaps.
        opa_q.push_back(64'h00000000_FFFFFFFF);
        opb_q.push_back(64'h00000000_00000001);
        stream(60, 100, 0);
        check_eq("gap_result", last_res, 64'h00000001_00000000);

        // Reset after two beats: partial operand discarded.
        step(1'b1, 32'hAAAA5555, 1'b1);
        step(1'b1, 32'h12345678, 1'b1);
        pulse_reset();
        opa_q.push_back(64'h00000002_00000003);
        opb_q.push_back(64'h00000004_00000005);
        stream(0, 100, 0);
        check_eq("post_rst1_result", last_res, 64'h00000006_00000008);

        // Reset while a result is waiting in OUT.
        step(1'b1, 32'hFFFFFFFF, 1'b0);
        step(1'b1, 32'hFFFFFFFF, 1'b0);
        step(1'b1, 32'h00000001, 1'b0);
        step(1'b1, 32'h00000000, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        pulse_reset();
        opa_q.push_back(64'h80000000_00000000);
        opb_q.push_back(64'h80000000_00000000);
        stream(0, 100, 0);
        check_eq("post_rst2_result", last_res, '0);

        // Randomized traffic on both sides.
        for (int i = 0; i < 40; i++) begin
            opa_q.push_back(rand_op());
            opb_q.push_back(rand_op());
        end
        stream(35, 50, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
